tower_battle_ctrl: RTL and testbench
====================================

TOWER_BATTLE_CTRL -- requirements
Module: tower_battle_ctrl

Interface
REQ-001 Parameter NREQ, default 4: attacking units per side.
REQ-002 Parameter MAX_LEVEL, default 9: final level index; level range 0..MAX_LEVEL.
REQ-003 Parameter RESOLVE_CYC, default 16: clk cycles held in RESOLVE.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 game_tick  in  1  one-clk game-rate enable pulse.
REQ-007 start  in  1  one-clk pulse; begins or restarts a game.
REQ-008 p_req  in  NREQ  player-unit attack requests against the enemy tower.
REQ-009 p_dmg  in  8*NREQ  player-unit damage; slice i = bits 8i+7..8i.
REQ-010 e_req, e_dmg  in  NREQ, 8*NREQ  enemy-unit requests and damage against the player tower.
REQ-011 p_tower_dead, e_tower_dead  in  1  dead flags from the two towers.
REQ-012 start_level  out  1  one-clk pulse to both towers.
REQ-013 e_attack_en, e_dmg_out  out  1, 8  damage strobe and value to the enemy tower.
REQ-014 p_attack_en, p_dmg_out  out  1, 8  damage strobe and value to the player tower.
REQ-015 p_grant, e_grant  out  NREQ  one-hot grant per side.
REQ-016 level  out  4  current level; won, lost  out  1  sticky game result.

Function
REQ-017 FSM states: IDLE, LAUNCH, BATTLE, RESOLVE, DONE.
REQ-018 IDLE: start -> LAUNCH; all other inputs ignored.
REQ-019 LAUNCH: start_level=1 for exactly one cycle, then BATTLE unconditionally.
REQ-020 BATTLE: on a cycle with game_tick=1, each side independently grants at most one requester, chosen round-robin.
REQ-021 Round-robin: search begins at that side's pointer; after a grant to index g, pointer <= (g+1) mod NREQ; with no request, pointer unchanged.
REQ-022 Grant, attack_en and dmg_out are registered; they are valid for exactly one cycle, the cycle after the game_tick; otherwise grant=0, attack_en=0, dmg_out=0.
REQ-023 Player grants drive the enemy tower (e_attack_en/e_dmg_out); enemy grants drive the player tower (p_attack_en/p_dmg_out).
REQ-024 BATTLE with p_tower_dead=1, including when e_tower_dead=1 in the same cycle: lost<=1, go to DONE; no grants issued that cycle.
REQ-025 BATTLE with e_tower_dead=1 only: if level==MAX_LEVEL, won<=1 and go to DONE; else level<=level+1 and go to RESOLVE.
REQ-026 RESOLVE: no grants; hold exactly RESOLVE_CYC cycles, then LAUNCH.
REQ-027 DONE: outputs idle; won/lost held; start -> clear won/lost, level<=0, pointers<=0, go to LAUNCH.
REQ-028 start in LAUNCH, BATTLE or RESOLVE is ignored.
REQ-029 game_tick outside BATTLE has no effect.

Reset
REQ-030 Reset: state=IDLE; level=0; both pointers=0; RESOLVE counter=0; every output 0.
REQ-031 Reset asserted mid-BATTLE drops any in-flight grant and strobe in the same cycle.

Configuration
REQ-032 Macro TOWER_BATTLE_LEVEL_SCALE_EN.
REQ-033 When defined: p_dmg_out = granted e_dmg + level, saturating at 255; player-side damage is unscaled.
REQ-034 When undefined: both sides pass the granted damage through unchanged.

Verification
REQ-035 reset, start -> start_level pulses 1 cycle, 1 cycle later state=BATTLE, level=0.
REQ-036 p_req=4'b1111, 5 ticks -> p_grant 0001, 0010, 0100, 1000, 0001; e_dmg_out equals the matching p_dmg slice each time.
REQ-037 e_tower_dead at level 0 -> level=1, 16 idle cycles, start_level pulses again.
REQ-038 p_tower_dead and e_tower_dead asserted in the same cycle -> lost=1, won=0, DONE; start -> level=0, lost=0, LAUNCH.
REQ-039 e_tower_dead at level 9 -> won=1, DONE, no further grants.
REQ-040 With macro defined, level=3, e_dmg slice=254 -> p_dmg_out=255; e_dmg=10 -> p_dmg_out=13.

Source files
------------

// File: rtl/tower_battle_ctrl_if.sv
// Signal bundle between the tower battle controller and its environment.
// Names carry the controller's view: _i are controller inputs, _o are controller outputs.
interface tower_battle_ctrl_if #(
    parameter int NREQ = 4
);
    logic                game_tick_i;
    logic                start_i;
    logic [NREQ-1:0]     p_req_i;
    logic [8*NREQ-1:0]   p_dmg_i;
    logic [NREQ-1:0]     e_req_i;
    logic [8*NREQ-1:0]   e_dmg_i;
    logic                p_tower_dead_i;
    logic                e_tower_dead_i;

    logic                start_level_o;
    logic                e_attack_en_o;
    logic [7:0]          e_dmg_out_o;
    logic                p_attack_en_o;
    logic [7:0]          p_dmg_out_o;
    logic [NREQ-1:0]     p_grant_o;
    logic [NREQ-1:0]     e_grant_o;
    logic [3:0]          level_o;
    logic                won_o;
    logic                lost_o;

    modport master (
        output game_tick_i, start_i, p_req_i, p_dmg_i, e_req_i, e_dmg_i,
               p_tower_dead_i, e_tower_dead_i,
        input  start_level_o, e_attack_en_o, e_dmg_out_o, p_attack_en_o, p_dmg_out_o,
               p_grant_o, e_grant_o, level_o, won_o, lost_o
    );

    modport slave (
        input  game_tick_i, start_i, p_req_i, p_dmg_i, e_req_i, e_dmg_i,
               p_tower_dead_i, e_tower_dead_i,
        output start_level_o, e_attack_en_o, e_dmg_out_o, p_attack_en_o, p_dmg_out_o,
               p_grant_o, e_grant_o, level_o, won_o, lost_o
    );
endinterface

// File: rtl/tower_battle_ctrl.sv
// Tower battle game controller: level sequencing plus round-robin attack arbitration per side.
// Optional macro TOWER_BATTLE_LEVEL_SCALE_EN adds the current level to enemy damage (saturating).
module tower_battle_ctrl #(
    parameter int NREQ        = 4,
    parameter int MAX_LEVEL   = 9,
    parameter int RESOLVE_CYC = 16
) (
    input logic               clk,
    input logic               reset,
    tower_battle_ctrl_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(RESOLVE_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        BATTLE,
        RESOLVE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      level_q, level_d;
    logic [PW-1:0]   pPtr_q, pPtr_d;
    logic [PW-1:0]   ePtr_q, ePtr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            won_q, won_d;
    logic            lost_q, lost_d;
    logic [NREQ-1:0] pGrant_q, pGrant_d;
    logic [NREQ-1:0] eGrant_q, eGrant_d;
    logic            eAttack_q, eAttack_d;
    logic            pAttack_q, pAttack_d;
    logic [7:0]      eDmg_q, eDmg_d;
    logic [7:0]      pDmg_q, pDmg_d;

    logic            pHit, eHit;
    logic [PW-1:0]   pIdx, eIdx, pCand, eCand;
    logic [7:0]      pSel, eSel;
    logic [8:0]      scaledSum;

    // Round-robin search from each side's pointer, plus the damage byte of the winner.
    always_comb begin
        pHit  = 1'b0;
        eHit  = 1'b0;
        pIdx  = '0;
        eIdx  = '0;
        pCand = '0;
        eCand = '0;
        pSel  = '0;
        eSel  = '0;
        for (int k = 0; k < NREQ; k++) begin
            pCand = PW'((int'(pPtr_q) + k) % NREQ);
            eCand = PW'((int'(ePtr_q) + k) % NREQ);
            if (!pHit && bus.p_req_i[pCand]) begin
                pHit = 1'b1;
                pIdx = pCand;
            end
            if (!eHit && bus.e_req_i[eCand]) begin
                eHit = 1'b1;
                eIdx = eCand;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (PW'(k) == pIdx) pSel = bus.p_dmg_i[8*k +: 8];
            if (PW'(k) == eIdx) eSel = bus.e_dmg_i[8*k +: 8];
        end
        scaledSum = {1'b0, eSel} + {5'b00000, level_q};
    end

    // Next-state and registered-output logic; grant outputs default to idle every cycle.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        pPtr_d    = pPtr_q;
        ePtr_d    = ePtr_q;
        cnt_d     = cnt_q;
        won_d     = won_q;
        lost_d    = lost_q;
        pGrant_d  = '0;
        eGrant_d  = '0;
        eAttack_d = 1'b0;
        pAttack_d = 1'b0;
        eDmg_d    = '0;
        pDmg_d    = '0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = LAUNCH;
            end
            LAUNCH: begin
                state_d = BATTLE;
            end
            BATTLE: begin
                if (bus.p_tower_dead_i) begin
                    lost_d  = 1'b1;
                    state_d = DONE;
                end else if (bus.e_tower_dead_i) begin
                    if (level_q == 4'(MAX_LEVEL)) begin
                        won_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        level_d = level_q + 4'd1;
                        cnt_d   = '0;
                        state_d = RESOLVE;
                    end
                end else if (bus.game_tick_i) begin
                    if (pHit) begin
                        pGrant_d[pIdx] = 1'b1;
                        eAttack_d      = 1'b1;
                        eDmg_d         = pSel;
                        pPtr_d         = (pIdx == PW'(NREQ - 1)) ? '0 : pIdx + 1'b1;
                    end
                    if (eHit) begin
                        eGrant_d[eIdx] = 1'b1;
                        pAttack_d      = 1'b1;
`ifdef TOWER_BATTLE_LEVEL_SCALE_EN
                        pDmg_d         = scaledSum[8] ? 8'hFF : scaledSum[7:0];
`else
                        pDmg_d         = eSel;
`endif
                        ePtr_d         = (eIdx == PW'(NREQ - 1)) ? '0 : eIdx + 1'b1;
                    end
                end
            end
            RESOLVE: begin
                if (cnt_q == CW'(RESOLVE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = LAUNCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.start_i) begin
                    won_d   = 1'b0;
                    lost_d  = 1'b0;
                    level_d = '0;
                    pPtr_d  = '0;
                    ePtr_d  = '0;
                    state_d = LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset clears in-flight grants immediately, not at the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            level_q   <= '0;
            pPtr_q    <= '0;
            ePtr_q    <= '0;
            cnt_q     <= '0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
            pGrant_q  <= '0;
            eGrant_q  <= '0;
            eAttack_q <= 1'b0;
            pAttack_q <= 1'b0;
            eDmg_q    <= '0;
            pDmg_q    <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            pPtr_q    <= pPtr_d;
            ePtr_q    <= ePtr_d;
            cnt_q     <= cnt_d;
            won_q     <= won_d;
            lost_q    <= lost_d;
            pGrant_q  <= pGrant_d;
            eGrant_q  <= eGrant_d;
            eAttack_q <= eAttack_d;
            pAttack_q <= pAttack_d;
            eDmg_q    <= eDmg_d;
            pDmg_q    <= pDmg_d;
        end
    end

    assign bus.start_level_o = (state_q == LAUNCH);
    assign bus.e_attack_en_o = eAttack_q;
    assign bus.e_dmg_out_o   = eDmg_q;
    assign bus.p_attack_en_o = pAttack_q;
    assign bus.p_dmg_out_o   = pDmg_q;
    assign bus.p_grant_o     = pGrant_q;
    assign bus.e_grant_o     = eGrant_q;
    assign bus.level_o       = level_q;
    assign bus.won_o         = won_q;
    assign bus.lost_o        = lost_q;
endmodule

// File: tb/tb_tower_battle_ctrl.sv
// Self-checking bench for tower_battle_ctrl against a behavioural game model.
// Expected enemy-side damage honours TOWER_BATTLE_LEVEL_SCALE_EN when defined.
module tb_tower_battle_ctrl;
    localparam int NREQ        = 4;
    localparam int MAX_LEVEL   = 9;
    localparam int RESOLVE_CYC = 16;
    localparam int W           = 2*NREQ + 18;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tower_battle_ctrl_if #(.NREQ(NREQ)) bus ();

    tower_battle_ctrl #(
        .NREQ(NREQ), .MAX_LEVEL(MAX_LEVEL), .RESOLVE_CYC(RESOLVE_CYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int mPPtr = 0;
    int mEPtr = 0;
    int mLevel = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.game_tick_i    = 1'b0;
        bus.start_i        = 1'b0;
        bus.p_req_i        = '0;
        bus.p_dmg_i        = '0;
        bus.e_req_i        = '0;
        bus.e_dmg_i        = '0;
        bus.p_tower_dead_i = 1'b0;
        bus.e_tower_dead_i = 1'b0;
    endtask

    function automatic logic [8*NREQ-1:0] randDmg();
        logic [8*NREQ-1:0] d;
        for (int i = 0; i < NREQ; i++) d[8*i +: 8] = 8'($urandom);
        return d;
    endfunction

    // First requester at or after ptr, wrapping; -1 when nobody asks.
    function automatic int rrRef(input logic [NREQ-1:0] req, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] scaleRef(input logic [7:0] d);
`ifdef TOWER_BATTLE_LEVEL_SCALE_EN
        int s;
        s = int'(d) + mLevel;
        return (s > 255) ? 8'd255 : 8'(s);
`else
        return d;
`endif
    endfunction

    function automatic logic [W-1:0] obsVec();
        return {bus.p_grant_o, bus.e_grant_o, bus.e_attack_en_o, bus.e_dmg_out_o,
                bus.p_attack_en_o, bus.p_dmg_out_o};
    endfunction

    // Drives one BATTLE cycle and returns what the model says the outputs become.
    task automatic driveBattle(input logic tick, input logic [NREQ-1:0] pr, input logic [NREQ-1:0] er,
                               input logic [8*NREQ-1:0] pd, input logic [8*NREQ-1:0] ed,
                               output logic [W-1:0] expV);
        int pi, ei;
        logic [NREQ-1:0] pg, eg;
        logic ea, pa;
        logic [7:0] eo, po;
        bus.game_tick_i = tick;
        bus.p_req_i = pr;
        bus.e_req_i = er;
        bus.p_dmg_i = pd;
        bus.e_dmg_i = ed;
        pi = tick ? rrRef(pr, mPPtr) : -1;
        ei = tick ? rrRef(er, mEPtr) : -1;
        pg = '0; eg = '0; ea = 1'b0; pa = 1'b0; eo = '0; po = '0;
        if (pi >= 0) begin
            pg[pi] = 1'b1; ea = 1'b1; eo = pd[8*pi +: 8]; mPPtr = (pi + 1) % NREQ;
        end
        if (ei >= 0) begin
            eg[ei] = 1'b1; pa = 1'b1; po = scaleRef(ed[8*ei +: 8]); mEPtr = (ei + 1) % NREQ;
        end
        expV = {pg, eg, ea, eo, pa, po};
        step();
        bus.game_tick_i = 1'b0;
    endtask

    // Kills the enemy tower below MAX_LEVEL and waits for the next level to be in BATTLE.
    task automatic advanceLevel();
        int n;
        bus.e_tower_dead_i = 1'b1;
        step();
        bus.e_tower_dead_i = 1'b0;
        mLevel++;
        n = 0;
        while (bus.start_level_o !== 1'b1 && n < 4*RESOLVE_CYC) begin
            step();
            n++;
        end
        total++;
        if (bus.start_level_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL relaunch_wait: start_level=%b after %0d cycles, want 1", bus.start_level_o, n);
        end
        step();
    endtask

    task automatic test_reset();
        idleInputs();
        reset = 1'b1;
        bus.p_req_i = 4'b1111;
        bus.game_tick_i = 1'b1;
        repeat (3) step();
        total++;
        if ({obsVec(), bus.start_level_o, bus.level_o, bus.won_o, bus.lost_o} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h want 0", {obsVec(), bus.start_level_o, bus.level_o, bus.won_o, bus.lost_o});
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.game_tick_i = 1'b1;
            bus.e_req_i = 4'($urandom);
            bus.p_tower_dead_i = 1'($urandom);
            step();
            total++;
            if ({obsVec(), bus.start_level_o, bus.level_o} !== '0) begin
                bad++;
                $display("[TB] FAIL idle_ignores: got %h want 0", {obsVec(), bus.start_level_o, bus.level_o});
            end
        end
        idleInputs();
        mPPtr = 0; mEPtr = 0; mLevel = 0;
    endtask

    task automatic test_launch();
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        total++;
        if (bus.start_level_o !== 1'b1 || bus.level_o !== 4'd0) begin
            bad++;
            $display("[TB] FAIL launch_pulse: start_level=%b level=%0d want 1/0", bus.start_level_o, bus.level_o);
        end
        step();
        total++;
        if (bus.start_level_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL launch_single: start_level=%b want 0", bus.start_level_o);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [W-1:0] expV;
        logic [8*NREQ-1:0] pd;
        for (int i = 0; i < 5; i++) begin
            pd = randDmg();
            driveBattle(1'b1, 4'b1111, '0, pd, randDmg(), expV);
            total++;
            if (obsVec() !== expV || bus.p_grant_o !== want[i]) begin
                bad++;
                $display("[TB] FAIL rr_tick%0d: got %h (grant %b) want %h (grant %b)", i, obsVec(), bus.p_grant_o, expV, want[i]);
            end
            driveBattle(1'b0, 4'b1111, 4'b1111, pd, randDmg(), expV);
            total++;
            if (obsVec() !== '0) begin
                bad++;
                $display("[TB] FAIL rr_gap%0d: got %h want 0", i, obsVec());
            end
        end
    endtask

    task automatic test_random_battle();
        logic [W-1:0] expV;
        for (int i = 0; i < 80; i++) begin
            bus.start_i = ($urandom_range(0, 7) == 0);
            driveBattle(1'($urandom), 4'($urandom), 4'($urandom), randDmg(), randDmg(), expV);
            total++;
            if (obsVec() !== expV) begin
                bad++;
                $display("[TB] FAIL random_battle%0d: got %h want %h", i, obsVec(), expV);
            end
        end
        bus.start_i = 1'b0;
    endtask

    task automatic test_level_up();
        int n;
        bus.e_tower_dead_i = 1'b1;
        bus.game_tick_i = 1'b1;
        bus.p_req_i = 4'b1111;
        bus.e_req_i = 4'b1111;
        step();
        bus.e_tower_dead_i = 1'b0;
        mLevel++;
        total++;
        if (bus.level_o !== 4'(mLevel) || obsVec() !== '0) begin
            bad++;
            $display("[TB] FAIL level_up: level=%0d out=%h want %0d/0", bus.level_o, obsVec(), mLevel);
        end
        n = 0;
        while (bus.start_level_o !== 1'b1 && n < 4*RESOLVE_CYC) begin
            bus.game_tick_i = 1'($urandom);
            bus.start_i = 1'($urandom);
            step();
            n++;
            total++;
            if (obsVec() !== '0) begin
                bad++;
                $display("[TB] FAIL resolve_quiet%0d: got %h want 0", n, obsVec());
            end
        end
        bus.game_tick_i = 1'b0;
        bus.start_i = 1'b0;
        total++;
        if (n !== RESOLVE_CYC || bus.start_level_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL resolve_len: relaunch after %0d cycles want %0d", n, RESOLVE_CYC);
        end
        step();
    endtask

    task automatic test_level_scale();
        logic [W-1:0] expV;
        logic [8*NREQ-1:0] ed;
        logic [7:0] want1, want2;
        while (mLevel < 3) advanceLevel();
`ifdef TOWER_BATTLE_LEVEL_SCALE_EN
        want1 = 8'd255; want2 = 8'd13;
`else
        want1 = 8'd254; want2 = 8'd10;
`endif
        ed = randDmg();
        ed[8*2 +: 8] = 8'd254;
        driveBattle(1'b1, '0, 4'b0100, randDmg(), ed, expV);
        total++;
        if (bus.p_dmg_out_o !== want1 || obsVec() !== expV) begin
            bad++;
            $display("[TB] FAIL scale_sat: p_dmg_out=%0d want %0d", bus.p_dmg_out_o, want1);
        end
        ed[8*2 +: 8] = 8'd10;
        driveBattle(1'b1, '0, 4'b0100, randDmg(), ed, expV);
        total++;
        if (bus.p_dmg_out_o !== want2 || obsVec() !== expV) begin
            bad++;
            $display("[TB] FAIL scale_add: p_dmg_out=%0d want %0d", bus.p_dmg_out_o, want2);
        end
    endtask

    task automatic test_double_dead();
        logic [W-1:0] expV;
        driveBattle(1'b1, 4'b0001, 4'b0001, randDmg(), randDmg(), expV);
        bus.p_tower_dead_i = 1'b1;
        bus.e_tower_dead_i = 1'b1;
        bus.game_tick_i = 1'b1;
        bus.p_req_i = 4'b1111;
        step();
        bus.p_tower_dead_i = 1'b0;
        bus.e_tower_dead_i = 1'b0;
        total++;
        if (bus.lost_o !== 1'b1 || bus.won_o !== 1'b0 || obsVec() !== '0 || bus.level_o !== 4'(mLevel)) begin
            bad++;
            $display("[TB] FAIL double_dead: lost=%b won=%b out=%h level=%0d want 1/0/0/%0d", bus.lost_o, bus.won_o, obsVec(), bus.level_o, mLevel);
        end
        repeat (3) step();
        total++;
        if (bus.lost_o !== 1'b1 || obsVec() !== '0) begin
            bad++;
            $display("[TB] FAIL done_hold: lost=%b out=%h want 1/0", bus.lost_o, obsVec());
        end
        bus.game_tick_i = 1'b0;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        mLevel = 0; mPPtr = 0; mEPtr = 0;
        total++;
        if (bus.start_level_o !== 1'b1 || bus.level_o !== 4'd0 || bus.lost_o !== 1'b0 || bus.won_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL restart: start_level=%b level=%0d lost=%b won=%b want 1/0/0/0", bus.start_level_o, bus.level_o, bus.lost_o, bus.won_o);
        end
        step();
        driveBattle(1'b1, 4'b1111, 4'b1111, randDmg(), randDmg(), expV);
        total++;
        if (obsVec() !== expV || bus.p_grant_o !== 4'b0001 || bus.e_grant_o !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL ptr_cleared: got %h want %h", obsVec(), expV);
        end
    endtask

    task automatic test_win();
        while (mLevel < MAX_LEVEL) advanceLevel();
        total++;
        if (bus.level_o !== 4'(MAX_LEVEL)) begin
            bad++;
            $display("[TB] FAIL climb: level=%0d want %0d", bus.level_o, MAX_LEVEL);
        end
        bus.e_tower_dead_i = 1'b1;
        bus.game_tick_i = 1'b1;
        bus.p_req_i = 4'b1111;
        bus.e_req_i = 4'b1111;
        step();
        bus.e_tower_dead_i = 1'b0;
        total++;
        if (bus.won_o !== 1'b1 || bus.lost_o !== 1'b0 || bus.level_o !== 4'(MAX_LEVEL) || obsVec() !== '0) begin
            bad++;
            $display("[TB] FAIL win: won=%b lost=%b level=%0d out=%h want 1/0/%0d/0", bus.won_o, bus.lost_o, bus.level_o, obsVec(), MAX_LEVEL);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (obsVec() !== '0 || bus.won_o !== 1'b1 || bus.start_level_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL win_quiet%0d: out=%h won=%b want 0/1", i, obsVec(), bus.won_o);
            end
        end
        bus.game_tick_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] expV;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        mLevel = 0; mPPtr = 0; mEPtr = 0;
        step();
        driveBattle(1'b1, 4'b1111, 4'b0110, randDmg(), randDmg(), expV);
        total++;
        if (obsVec() !== expV) begin
            bad++;
            $display("[TB] FAIL pre_reset_grant: got %h want %h", obsVec(), expV);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({obsVec(), bus.level_o, bus.won_o, bus.lost_o, bus.start_level_o} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid: got %h want 0", {obsVec(), bus.level_o, bus.won_o, bus.lost_o, bus.start_level_o});
        end
        step();
        reset = 1'b0;
        idleInputs();
        step();
    endtask

    initial begin
        test_reset();
        test_launch();
        test_round_robin();
        test_random_battle();
        test_level_up();
        test_level_scale();
        test_double_dead();
        test_win();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
